// File: rtl/apb_arbiter.sv
// Two-requester round-robin arbiter driving a single APB3 master port.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    output logic        req0_done,
    output logic [31:0] req0_rdata,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [31:0] req1_rdata,
    output logic        req1_err,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PSEL,
    output logic        PENABLE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e state_q, state_d;
    logic   gnt_q;
    logic   last_q;
    logic   grant_any;
    logic   grant_sel;
    logic   grant_now;
    logic   timeout_hit;

    // Contest goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_sel = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        grant_now = (state_q == StIdle) && grant_any;
        req0_ready = grant_now && !grant_sel;
        req1_ready = grant_now && grant_sel;
        PSEL    = (state_q != StIdle);
        PENABLE = (state_q == StAccess);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (grant_any) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (PREADY || timeout_hit) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] tmo_cnt_q;

    always_ff @(posedge PCLK) begin
        if (PRESET || grant_now) begin
            tmo_cnt_q <= '0;
        end else if (state_q == StAccess && !PREADY) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive wait cycle.
    assign timeout_hit = (state_q == StAccess) && !PREADY &&
                         (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= StIdle;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            PADDR      <= '0;
            PWDATA     <= '0;
            PWRITE     <= 1'b0;
            req0_done  <= 1'b0;
            req0_rdata <= '0;
            req0_err   <= 1'b0;
            req1_done  <= 1'b0;
            req1_rdata <= '0;
            req1_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            if (grant_now) begin
                gnt_q  <= grant_sel;
                PADDR  <= grant_sel ? req1_addr  : req0_addr;
                PWDATA <= grant_sel ? req1_wdata : req0_wdata;
                PWRITE <= grant_sel ? req1_write : req0_write;
            end
            if (state_q == StAccess && PREADY) begin
                last_q <= gnt_q;
                if (gnt_q) begin
                    req1_done <= 1'b1;
                    req1_err  <= PSLVERR;
                    if (!PWRITE) req1_rdata <= PRDATA;
                end else begin
                    req0_done <= 1'b1;
                    req0_err  <= PSLVERR;
                    if (!PWRITE) req0_rdata <= PRDATA;
                end
            end else if (timeout_hit) begin
                last_q <= gnt_q;
                if (gnt_q) begin
                    req1_done  <= 1'b1;
                    req1_err   <= 1'b1;
                    req1_rdata <= '0;
                end else begin
                    req0_done  <= 1'b1;
                    req0_err   <= 1'b1;
                    req0_rdata <= '0;
                end
            end
        end
    end

endmodule
